// File: rtl/portarb.sv
// rtl/portarb.sv - N-channel scratchpad port arbiter with lockable bursts and registered RAM stage
module portarb #(
    parameter int N       = 3,
    parameter int a       = 9,
    parameter int w       = 128,
    parameter int MODE    = 0,
    parameter int MAXLOCK = 4,
    localparam int IW     = $clog2(N),
    localparam int CW     = $clog2(MAXLOCK) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   csel,
    input  logic [N-1:0]   lock,
    input  logic [N*a-1:0] addrin,
    input  logic [N*w-1:0] datain,
    output logic [N-1:0]   grnt,
    output logic [a-1:0]   addr,
    output logic [w-1:0]   data,
    output logic           vld,
    output logic [IW-1:0]  gidx
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] gidx_q, gidx_d;
    logic          lockv_q, lockv_d;
    logic          vld_q, vld_d;
    logic [CW-1:0] lkcnt_q, lkcnt_d;
    logic [a-1:0]  addr_q, addr_d;
    logic [w-1:0]  data_q, data_d;

    logic          win_vld;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;

    // A live lock only holds while its owner keeps requesting; otherwise arbitrate normally.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        if (!rst) begin
            if (lockv_q && csel[owner_q]) begin
                win_vld = 1'b1;
                win_idx = owner_q;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (MODE == 1) begin
                        cand = IW'((int'(ptr_q) + i) % N);
                    end else begin
                        cand = IW'(i);
                    end
                    if (!win_vld && csel[cand]) begin
                        win_vld = 1'b1;
                        win_idx = cand;
                    end
                end
            end
        end
    end

    assign grnt = win_vld ? (N'(1) << win_idx) : '0;

    always_comb begin
        ptr_d   = ptr_q;
        owner_d = owner_q;
        lockv_d = 1'b0;
        lkcnt_d = '0;
        addr_d  = addr_q;
        data_d  = data_q;
        gidx_d  = gidx_q;
        vld_d   = win_vld;
        if (win_vld) begin
            addr_d = addrin[int'(win_idx)*a +: a];
            data_d = datain[int'(win_idx)*w +: w];
            gidx_d = win_idx;
            // Pointer advances even on locked grants so a forced release hands over fairly.
            if (MODE == 1) begin
                ptr_d = (win_idx == IW'(N-1)) ? '0 : win_idx + 1'b1;
            end
            if (lock[win_idx] && (lkcnt_q < CW'(MAXLOCK-1))) begin
                lockv_d = 1'b1;
                owner_d = win_idx;
                lkcnt_d = lkcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            owner_q <= '0;
            lockv_q <= 1'b0;
            lkcnt_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            gidx_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            lockv_q <= lockv_d;
            lkcnt_q <= lkcnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            gidx_q  <= gidx_d;
            vld_q   <= vld_d;
        end
    end

    assign addr = addr_q;
    assign data = data_q;
    assign vld  = vld_q;
    assign gidx = gidx_q;

endmodule

// File: tb/tb_portarb.sv
// tb/tb_portarb.sv - vector table and scoreboard bench for fixed-priority and round-robin portarb
module tb_portarb;
    localparam int N  = 3;
    localparam int A  = 9;
    localparam int W  = 128;
    localparam int ML = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   csel_fp, lock_fp, csel_rr, lock_rr, grnt_fp, grnt_rr;
    logic [N*A-1:0] addrin;
    logic [N*W-1:0] datain;
    logic [A-1:0]   addr_fp, addr_rr;
    logic [W-1:0]   data_fp, data_rr;
    logic           vld_fp, vld_rr;
    logic [1:0]     gidx_fp, gidx_rr;

    always #5 clk = ~clk;

    portarb #(.N(N), .a(A), .w(W), .MODE(0), .MAXLOCK(ML)) u_fp (
        .clk(clk), .rst(rst), .csel(csel_fp), .lock(lock_fp),
        .addrin(addrin), .datain(datain), .grnt(grnt_fp),
        .addr(addr_fp), .data(data_fp), .vld(vld_fp), .gidx(gidx_fp)
    );

    portarb #(.N(N), .a(A), .w(W), .MODE(1), .MAXLOCK(ML)) u_rr (
        .clk(clk), .rst(rst), .csel(csel_rr), .lock(lock_rr),
        .addrin(addrin), .datain(datain), .grnt(grnt_rr),
        .addr(addr_rr), .data(data_rr), .vld(vld_rr), .gidx(gidx_rr)
    );

    typedef struct {
        logic       rr;
        logic       rst;
        logic [2:0] csel;
        logic [2:0] lock;
        logic [2:0] exp_grnt;
    } vec_t;

    typedef struct {
        logic         vld;
        logic [1:0]   gidx;
        logic [A-1:0] addr;
        logic [W-1:0] data;
    } exp_t;

    exp_t q_fp[$];
    exp_t q_rr[$];
    exp_t hold_fp, hold_rr;
    vec_t vt[$];
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic rr, input logic r, input logic [2:0] c,
                                input logic [2:0] l, input logic [2:0] g);
        vec_t v;
        v.rr = rr; v.rst = r; v.csel = c; v.lock = l; v.exp_grnt = g;
        return v;
    endfunction

    function automatic exp_t next_exp(input exp_t hold, input logic r, input logic [2:0] g);
        exp_t e;
        if (r) begin
            e.vld = 1'b0; e.gidx = '0; e.addr = '0; e.data = '0;
        end else begin
            e = hold;
            e.vld = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (g[k]) begin
                    e.vld  = 1'b1;
                    e.gidx = 2'(k);
                    e.addr = addrin[k*A +: A];
                    e.data = datain[k*W +: W];
                end
            end
        end
        return e;
    endfunction

    task automatic check_regs();
        exp_t e;
        if (q_fp.size() > 0) begin
            e = q_fp.pop_front();
            chk("fp_vld", W'(vld_fp), W'(e.vld));
            chk("fp_gidx", W'(gidx_fp), W'(e.gidx));
            chk("fp_addr", W'(addr_fp), W'(e.addr));
            chk("fp_data", data_fp, e.data);
        end
        if (q_rr.size() > 0) begin
            e = q_rr.pop_front();
            chk("rr_vld", W'(vld_rr), W'(e.vld));
            chk("rr_gidx", W'(gidx_rr), W'(e.gidx));
            chk("rr_addr", W'(addr_rr), W'(e.addr));
            chk("rr_data", data_rr, e.data);
        end
    endtask

    task automatic apply(input vec_t v);
        logic [2:0] gf, gr;
        @(negedge clk);
        check_regs();
        rst     = v.rst;
        csel_fp = v.rr ? 3'b000 : v.csel;
        lock_fp = v.rr ? 3'b000 : v.lock;
        csel_rr = v.rr ? v.csel : 3'b000;
        lock_rr = v.rr ? v.lock : 3'b000;
        for (int k = 0; k < N; k++) begin
            addrin[k*A +: A] = A'($urandom);
            datain[k*W +: W] = {$urandom, $urandom, $urandom, $urandom};
        end
        #1;
        gf = v.rr ? 3'b000 : v.exp_grnt;
        gr = v.rr ? v.exp_grnt : 3'b000;
        chk("fp_grnt", W'(grnt_fp), W'(gf));
        chk("rr_grnt", W'(grnt_rr), W'(gr));
        hold_fp = next_exp(hold_fp, v.rst, gf);
        hold_rr = next_exp(hold_rr, v.rst, gr);
        q_fp.push_back(hold_fp);
        q_rr.push_back(hold_rr);
    endtask

    initial begin
        rst = 1'b1; csel_fp = '0; lock_fp = '0; csel_rr = '0; lock_rr = '0;
        addrin = '0; datain = '0;
        hold_fp = '{vld: 1'b0, gidx: '0, addr: '0, data: '0};
        hold_rr = hold_fp;

        // Reset, fixed priority, hold-on-idle, non-winner lock ignored
        vt.push_back(mk(0, 1, 3'b111, 3'b000, 3'b000));
        vt.push_back(mk(0, 0, 3'b111, 3'b000, 3'b001));
        vt.push_back(mk(0, 0, 3'b110, 3'b000, 3'b010));
        vt.push_back(mk(0, 0, 3'b110, 3'b000, 3'b010));
        vt.push_back(mk(0, 0, 3'b110, 3'b000, 3'b010));
        vt.push_back(mk(0, 0, 3'b000, 3'b000, 3'b000));
        vt.push_back(mk(0, 0, 3'b101, 3'b000, 3'b001));
        vt.push_back(mk(0, 0, 3'b100, 3'b000, 3'b100));
        vt.push_back(mk(0, 0, 3'b110, 3'b100, 3'b010));
        vt.push_back(mk(0, 0, 3'b111, 3'b000, 3'b001));
        // Round-robin rotation
        vt.push_back(mk(1, 1, 3'b111, 3'b000, 3'b000));
        vt.push_back(mk(1, 0, 3'b111, 3'b000, 3'b001));
        vt.push_back(mk(1, 0, 3'b111, 3'b000, 3'b010));
        vt.push_back(mk(1, 0, 3'b111, 3'b000, 3'b100));
        vt.push_back(mk(1, 0, 3'b111, 3'b000, 3'b001));
        vt.push_back(mk(1, 0, 3'b111, 3'b000, 3'b010));
        vt.push_back(mk(1, 0, 3'b111, 3'b000, 3'b100));
        // Move ptr to 1, then lock cap on channel 1
        vt.push_back(mk(1, 0, 3'b001, 3'b000, 3'b001));
        vt.push_back(mk(1, 0, 3'b111, 3'b010, 3'b010));
        vt.push_back(mk(1, 0, 3'b111, 3'b010, 3'b010));
        vt.push_back(mk(1, 0, 3'b111, 3'b010, 3'b010));
        vt.push_back(mk(1, 0, 3'b111, 3'b010, 3'b010));
        vt.push_back(mk(1, 0, 3'b111, 3'b010, 3'b100));
        vt.push_back(mk(1, 0, 3'b111, 3'b010, 3'b001));
        vt.push_back(mk(1, 0, 3'b111, 3'b010, 3'b010));
        vt.push_back(mk(1, 0, 3'b111, 3'b010, 3'b010));

        for (int i = 0; i < vt.size(); i++) apply(vt[i]);

        // Reset in the middle of a burst
        @(posedge clk); #1;
        chk("rr_lkcnt_mid", W'(u_rr.lkcnt_q), W'(2));
        chk("rr_lockv_mid", W'(u_rr.lockv_q), W'(1));
        apply(mk(1, 1, 3'b111, 3'b010, 3'b000));
        apply(mk(1, 0, 3'b111, 3'b000, 3'b001));

        // Owner drops csel in second burst cycle
        apply(mk(1, 0, 3'b100, 3'b100, 3'b100));
        @(posedge clk); #1;
        chk("rr_lockv_set", W'(u_rr.lockv_q), W'(1));
        chk("rr_lkcnt_set", W'(u_rr.lkcnt_q), W'(1));
        apply(mk(1, 0, 3'b001, 3'b100, 3'b001));
        @(posedge clk); #1;
        chk("rr_lockv_abort", W'(u_rr.lockv_q), W'(0));
        chk("rr_lkcnt_abort", W'(u_rr.lkcnt_q), W'(0));
        apply(mk(1, 0, 3'b111, 3'b000, 3'b010));

        @(negedge clk);
        check_regs();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/portarb.md
# portarb

Parametrised N-channel scratchpad port arbiter with a registered output stage. It succeeds the three-way fixed-priority port multiplexer in front of each MVU memory port. It selects one of N requesting channels per cycle under a fixed-priority or round-robin policy, and supports locked bursts with a bounded hold length. It presents the winner's address/data to the RAM port one cycle later with a valid strobe.

## Interface
- `N`, 3: number of requesting channels (≥2); channel 0 is the former IC port, 1 MVU, 2 Ctrl.
- `a`, 9: address width.
- `w`, 128: data width.
- `MODE`, 0: 0 = fixed priority (channel 0 highest); 1 = round-robin.
- `MAXLOCK`, 4: maximum consecutive grants in one locked burst (≥1; 1 disables locking).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `csel`  in  N  per-channel request.
- `lock`  in  N  per-channel burst-lock request; meaningful only with `csel`.
- `addrin`  in  N*a  channel k address at `[k*a +: a]`.
- `datain`  in  N*w  channel k data at `[k*w +: w]`.
- `grnt`  out  N  one-hot grant, combinational, same cycle as request.
- `addr`  out  a  registered address to RAM port.
- `data`  out  w  registered data to RAM port.
- `vld`  out  1  registered: `addr`/`data` carry a granted access.
- `gidx`  out  clog2(N)  registered index of the channel that produced `addr`/`data`.

## Operation
State:
- `ptr` (clog2(N) bits): round-robin priority pointer.
- `lockv`, `owner` (clog2(N) bits): active lock.
- `lkcnt` (clog2(MAXLOCK)+1 bits).

Grant selection, combinational, in cycle t:
- `rst`=1: `grnt`=0.
- Else if `lockv` and `csel[owner]`: `grnt` = one-hot(`owner`); all other requests are denied.
- Else if `MODE`=0: lowest-indexed k with `csel[k]`=1 wins.
- Else (`MODE`=1): first k with `csel[k]`=1 scanning `ptr`, `ptr+1`, … mod N.
- No request: `grnt`=0.
- `grnt` is always zero- or one-hot.

State update at the edge ending cycle t, when channel k was granted:
- `addr` ← addrin[k], `data` ← datain[k], `gidx` ← k, `vld` ← 1.
- `MODE`=1: `ptr` ← (k+1) mod N, including locked grants. `MODE`=0: `ptr` stays 0.
- If `lock[k]`=1 and `lkcnt` < MAXLOCK−1: `lockv` ← 1, `owner` ← k, `lkcnt` ← `lkcnt`+1.
- If `lock[k]`=1 and `lkcnt` = MAXLOCK−1 (forced release): `lockv` ← 0, `lkcnt` ← 0. The next cycle uses normal arbitration; in RR the pointer is already past k.
- If `lock[k]`=0: `lockv` ← 0, `lkcnt` ← 0.

State update at the edge ending cycle t, when there is no grant:
- `vld` ← 0.
- `addr`, `data`, `gidx` hold their values (never X).
- `lockv` ← 0, `lkcnt` ← 0.

Lock boundaries:
- Owner drops `csel` while `lockv`=1: the lock is void that cycle and normal arbitration applies the same cycle.
- Another channel's `lock` is ignored unless that channel wins.

## Timing
- Reset values (cycle after `rst` sampled high): `vld`=0, `addr`=0, `data`=0, `gidx`=0, `ptr`=0, `lockv`=0, `lkcnt`=0. `grnt`=0 while `rst`=1.
- Reset mid-burst drops the lock. The first post-reset arbitration is fresh, with `ptr`=0.
- Latency: `grnt` in cycle t; `addr`/`data`/`vld`/`gidx` valid in cycle t+1.
- Throughput: one access per cycle, no bubbles between back-to-back grants.
- A requester whose `grnt`=0 must hold `csel`/`addrin`/`datain` and retry. No request queueing inside the block.
- Maximum wait for a continuously requesting channel in `MODE`=1 is (N−1)·MAXLOCK cycles. `MODE`=0 gives no guarantee.

## Test plan
- **Reset:** assert `rst` with all `csel`=3'b111 → `grnt`=0 during reset. The cycle after release gives `vld`=0, `addr`=0, `data`=0; the first grant is channel 0.
- **Fixed priority (N=3, MODE=0):** `csel`=3'b110 for 3 cycles → `grnt`=3'b010 every cycle. `addr` equals addrin[1] one cycle later. `vld`=1 for 3 cycles, then 0 with `addr` held.
- **Round-robin (MODE=1):** `csel`=3'b111 held for 6 cycles → `grnt` sequence 001, 010, 100, 001, 010, 100. `gidx` sequence 0, 1, 2, 0, 1, 2, delayed by one cycle.
- **Lock cap (MODE=1, MAXLOCK=4):** `csel`=3'b111, `lock`=3'b010 held, starting with `ptr`=1 → channel 1 granted 4 consecutive cycles, then channel 2, then 0, then channel 1 locks again.
- **Lock abort:** channel 2 locked; it drops `csel` in its second burst cycle while channel 0 requests → channel 0 is granted that same cycle. `lockv` and `lkcnt` are 0 next cycle.
- **Reset mid-burst:** channel 1 locked with `lkcnt`=2, `rst` pulsed for 1 cycle with all requesting → after reset, channel 0 wins (`ptr`=0) and `vld`=0 in the reset-following cycle.
